// File: rtl/cla_sub_4stage_32_if.sv
`timescale 1ns/1ps
// Operand-in / result-out handshake bundle for the 4-stage CLA subtractor.
//   in_valid/in_ready/in_a/in_b       : operand pair stream (minuend, subtrahend)
//   out_valid/out_ready/out_diff/...  : result stream (difference, borrow, overflow)
// master = producer of operands and consumer of results; slave = the subtractor.
interface cla_sub_4stage_32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_diff;
    logic        out_borrow;
    logic        out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, out_ovf
    );
endinterface

// File: rtl/cla_sub_4stage_32.sv
`timescale 1ns/1ps
// 32-bit subtractor (a + ~b + 1) split into four 8-bit carry-lookahead stages,
// one stage per pipeline register, with a valid/ready stream at each end.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of cla_sub_4stage_32_if (operands in, diff/borrow/ovf out)
// The whole pipeline advances together on en = !out_valid || out_ready;
// in_ready is that enable, so a stall at the output freezes every stage.
module cla_sub_4stage_32 (
    input  logic                   clock,
    input  logic                   reset,
    cla_sub_4stage_32_if.slave     bus
);

    localparam int unsigned W     = 32;
    localparam int unsigned SLICE = 8;

    // 4-bit lookahead group: returns {group_generate, group_propagate, sum[3:0]}
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       gg;
        logic       pg;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
        return {gg, pg, p ^ c};
    endfunction

    // 8-bit slice built from two lookahead groups: returns {carry_out, sum[7:0]}
    function automatic logic [SLICE:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [5:0] lo;
        logic [5:0] hi;
        logic       c4;
        logic       c8;
        lo = cla4(a[3:0], b[3:0], cin);
        c4 = lo[5] | (lo[4] & cin);
        hi = cla4(a[7:4], b[7:4], c4);
        c8 = hi[5] | (hi[4] & c4);
        return {c8, hi[3:0], lo[3:0]};
    endfunction

    logic en;

    // stage 0 register: bits [7:0] resolved, upper operand bits carried along
    logic        s0_valid;
    logic        s0_c;
    logic [7:0]  s0_diff;
    logic [23:0] s0_a;
    logic [23:0] s0_b;
    // stage 1 register: bits [15:0] resolved
    logic        s1_valid;
    logic        s1_c;
    logic [15:0] s1_diff;
    logic [15:0] s1_a;
    logic [15:0] s1_b;
    // stage 2 register: bits [23:0] resolved
    logic        s2_valid;
    logic        s2_c;
    logic [23:0] s2_diff;
    logic [7:0]  s2_a;
    logic [7:0]  s2_b;
    // stage 3 register: final result
    logic          out_valid_r;
    logic [W-1:0]  out_diff_r;
    logic          out_borrow_r;
    logic          out_ovf_r;

    logic [SLICE:0] st0;
    logic [SLICE:0] st1;
    logic [SLICE:0] st2;
    logic [SLICE:0] st3;
    logic           ovf_c;

    assign en           = !out_valid_r || bus.out_ready;
    assign bus.in_ready = en;

    // Per-stage slice adders; subtrahend slices are inverted, stage 0 injects the +1
    always_comb begin
        st0   = cla8(bus.in_a[7:0], ~bus.in_b[7:0], 1'b1);
        st1   = cla8(s0_a[7:0], ~s0_b[7:0], s0_c);
        st2   = cla8(s1_a[7:0], ~s1_b[7:0], s1_c);
        st3   = cla8(s2_a, ~s2_b, s2_c);
        // signed overflow: operand signs differ and result sign differs from minuend
        ovf_c = (s2_a[7] != s2_b[7]) && (st3[7] != s2_a[7]);
    end

    // Pipeline registers: all stages shift together on en, hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s0_valid     <= 1'b0;
            s0_c         <= 1'b0;
            s0_diff      <= '0;
            s0_a         <= '0;
            s0_b         <= '0;
            s1_valid     <= 1'b0;
            s1_c         <= 1'b0;
            s1_diff      <= '0;
            s1_a         <= '0;
            s1_b         <= '0;
            s2_valid     <= 1'b0;
            s2_c         <= 1'b0;
            s2_diff      <= '0;
            s2_a         <= '0;
            s2_b         <= '0;
            out_valid_r  <= 1'b0;
            out_diff_r   <= '0;
            out_borrow_r <= 1'b0;
            out_ovf_r    <= 1'b0;
        end else if (en) begin
            s0_valid     <= bus.in_valid;
            s0_c         <= st0[SLICE];
            s0_diff      <= st0[7:0];
            s0_a         <= bus.in_a[31:8];
            s0_b         <= bus.in_b[31:8];

            s1_valid     <= s0_valid;
            s1_c         <= st1[SLICE];
            s1_diff      <= {st1[7:0], s0_diff};
            s1_a         <= s0_a[23:8];
            s1_b         <= s0_b[23:8];

            s2_valid     <= s1_valid;
            s2_c         <= st2[SLICE];
            s2_diff      <= {st2[7:0], s1_diff};
            s2_a         <= s1_a[15:8];
            s2_b         <= s1_b[15:8];

            out_valid_r  <= s2_valid;
            out_diff_r   <= {st3[7:0], s2_diff};
            // borrow is the inverted carry-out of bit 31
            out_borrow_r <= ~st3[SLICE];
            out_ovf_r    <= ovf_c;
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_diff   = out_diff_r;
    assign bus.out_borrow = out_borrow_r;
    assign bus.out_ovf    = out_ovf_r;

endmodule

// File: doc/cla_sub_4stage_32.md
CLA_SUB_4STAGE_32 -- requirements
Module: cla_sub_4stage_32

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and depth at 4 pipeline stages.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 in_valid  input  1  in_a/in_b hold a valid operand pair this cycle.
REQ-005 in_ready  output  1  block will accept an operand pair this cycle.
REQ-006 in_a  input  32  minuend, unsigned or two's complement.
REQ-007 in_b  input  32  subtrahend, unsigned or two's complement.
REQ-008 out_valid  output  1  out_diff/out_borrow/out_ovf hold a result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_diff  output  32  (in_a - in_b) mod 2^32.
REQ-011 out_borrow  output  1  1 when in_a < in_b as unsigned values.
REQ-012 out_ovf  output  1  1 on two's-complement signed overflow of in_a - in_b.

Function
REQ-013 Subtraction SHALL be computed as in_a + ~in_b + 1 using carry-lookahead logic, with 4-bit lookahead groups inside each stage.
REQ-014 Stage k (k = 0..3) SHALL resolve bits [8k+7:8k] from the carry registered by stage k-1; stage 0 uses carry-in 1.
REQ-015 Unprocessed operand slices SHALL be delayed alongside the partial result so that each stage sees operands belonging to the same transaction.
REQ-016 out_borrow SHALL equal the inverse of the carry-out of bit 31.
REQ-017 out_ovf SHALL be 1 exactly when in_a[31] != in_b[31] and out_diff[31] != in_a[31].
REQ-018 A transfer SHALL occur on an input edge where in_valid && in_ready, and on an output edge where out_valid && out_ready.
REQ-019 Global advance enable SHALL be en = !out_valid || out_ready.
REQ-020 in_ready SHALL equal en (combinational).
REQ-021 When en = 1, every stage SHALL shift forward one position on the edge, and stage 0 SHALL load the input pair with valid = in_valid && in_ready.
REQ-022 When en = 0, all stage registers, including data and valid bits, SHALL hold their values.
REQ-023 Latency without stall SHALL be exactly 4 cycles: a pair accepted at edge N produces out_valid = 1 after edge N+3 and is presented in the cycle following that edge.
REQ-024 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-025 Invalid slots (bubbles) SHALL propagate like data and never assert out_valid.
REQ-026 While out_valid && !out_ready, out_diff, out_borrow and out_ovf SHALL remain stable.
REQ-027 Results SHALL leave in acceptance order, with no loss or duplication.
REQ-028 in_a and in_b SHALL be ignored when no transfer occurs.

Reset
REQ-029 While reset = 0, all valid bits, the carry register, all data registers, out_valid, out_diff, out_borrow and out_ovf SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight transactions, and no stale result SHALL appear after release.
REQ-032 The first edge after reset release SHALL accept input normally.

Verification
REQ-033 Accept 5 - 3 at edge N with out_ready = 1 -> after edge N+3: out_valid = 1, out_diff = 2, out_borrow = 0, out_ovf = 0; out_valid = 0 before that edge.
REQ-034 Apply 0 - 1 -> out_diff = 0xFFFFFFFF, out_borrow = 1, out_ovf = 0.
REQ-035 Apply 0x80000000 - 1 -> out_diff = 0x7FFFFFFF, out_borrow = 0, out_ovf = 1.
REQ-036 Apply 0x7FFFFFFF - 0xFFFFFFFF -> out_diff = 0x80000000, out_borrow = 1, out_ovf = 1.
REQ-037 Send 6 back-to-back pairs and hold out_ready = 0 for 3 cycles once out_valid rises -> in_ready = 0 and outputs frozen during the stall; all 6 results arrive in order, each exactly once.
REQ-038 Run 10000 random pairs with random in_valid/out_ready and a reset pulse with 3 pairs in flight -> every accepted post-reset pair matches a - b (with borrow and ovf), and no pre-reset result is emitted.
